multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle control sequencer for the sequential RV64 core.
//  Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Drives ALUOp and operand-select into the execute stage, and the register-file and memory enables.
//  Handles the memory ready handshake, timeout, illegal opcodes and halt.
// PARAMETERS
//  MEM_WAIT_MAX  15  max cycles mem_req may stay high without mem_ready before timeout (>=1)
//  CNT_W         32  width of retired-instruction counter
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      asynchronous, active-high reset
//  start         in   1      leave IDLE and begin fetching
//  halt_req      in   1      stop at next instruction boundary
//  opcode        in   7      instr[6:0] from the instruction register (valid from DECODE on)
//  mem_ready     in   1      memory completes current request this cycle
//  state         out  3      IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
//  ir_we         out  1      load the instruction register
//  pc_we         out  1      update pc from execute-stage pcb
//  alu_op        out  2      ALUOp to execute: 00 add, 01 sub/branch, 10 funct-decoded
//  alu_src       out  1      0 = rs2, 1 = imm as ALU B operand
//  mem_req       out  1      memory request valid
//  mem_we        out  1      memory write (valid only with mem_req)
//  reg_we        out  1      register-file write enable
//  wb_sel        out  1      0 = ALU result (valE), 1 = load data
//  busy          out  1      state not IDLE and not HALT
//  instr_done    out  1      one-cycle pulse per retired instruction
//  illegal       out  1      sticky: unsupported opcode decoded
//  timeout_err   out  1      sticky: memory wait exceeded MEM_WAIT_MAX
//  retired       out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=IDLE; class, wait counter, retired, illegal and timeout_err = 0; all other outputs decode to 0.
//  Registers: state, class (R/LD/SD/BR), wait counter, retired, sticky flags. Outputs decode combinationally from state, class, mem_ready.
//  DECODE classes: 0110011=R, 0000011=LD, 0100011=SD, 1100011=BR.
//    1110011 (system) -> HALT, no flag. Any other opcode -> HALT with illegal=1.
//  IDLE: start=1 -> FETCH. halt_req is ignored in IDLE.
//  FETCH: mem_req=1, mem_we=0.
//    mem_ready=1 -> ir_we=1 -> DECODE.
//    Otherwise the wait counter increments; counter==MEM_WAIT_MAX -> HALT with timeout_err=1.
//  FETCH entry: if halt_req=1 at the retire edge, go to IDLE instead of FETCH.
//  Wait counter clears on every FETCH or MEM entry.
//  EXEC: alu_op = 00 for LD/SD, 01 for BR, 10 for R. alu_src=1 for LD/SD, else 0.
//    BR: pc_we=1, instr_done=1 -> FETCH (1 exec cycle; pcb selects the taken/not-taken target).
//    R -> WB. LD/SD -> MEM.
//  MEM: mem_req=1, mem_we=(class==SD). alu_op/alu_src are held at EXEC values so the address stays stable.
//    mem_ready: LD -> WB; SD -> pc_we=1, instr_done=1 -> FETCH.
//    Timeout handling is the same as in FETCH.
//  WB: reg_we=1, wb_sel=(class==LD), pc_we=1, instr_done=1 -> FETCH.
//  HALT: all strobes 0; only reset exits.
//  Latency with mem_ready tied high:
//    R = 4 cycles (F,D,E,W); BR = 3; SD = 4; LD = 5.
//  retired increments on every instr_done cycle.
//  mem_ready outside FETCH/MEM is ignored. start outside IDLE is ignored.
//  Reset mid-operation aborts immediately with no partial strobes; the next instruction starts from IDLE.
// TESTING
//  1. Reset; start=1 with mem_ready=1, R opcode 0110011.
//     -> states 1,2,3,5,1; reg_we and instr_done on the WB cycle; retired=1.
//  2. LD with mem_ready low 3 cycles in MEM.
//     -> mem_req held 4 cycles; alu_op=00 stable; then WB with wb_sel=1; total 8 cycles.
//  3. BR opcode 1100011.
//     -> alu_op=01 in EXEC, pc_we pulse, back in FETCH after 3 cycles, reg_we never 1.
//  4. Opcode 0000000 -> HALT, illegal=1, busy=0; start ignored until reset.
//  5. mem_ready held 0 in FETCH -> timeout_err=1 and HALT after MEM_WAIT_MAX=15 wait cycles.
//  6. halt_req=1 during SD: retires (retired+1) then IDLE.
//     Also: assert reset in MEM -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the RV64 datapath/memory side.
// The sequencer takes the master modport; the datapath/stimulus side takes the slave modport.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             halt_req;
  logic [6:0]       opcode;
  logic             mem_ready;

  logic [2:0]       state;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       alu_op;
  logic             alu_src;
  logic             mem_req;
  logic             mem_we;
  logic             reg_we;
  logic             wb_sel;
  logic             busy;
  logic             instr_done;
  logic             illegal;
  logic             timeout_err;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, halt_req, opcode, mem_ready,
    output state, ir_we, pc_we, alu_op, alu_src, mem_req, mem_we,
           reg_we, wb_sel, busy, instr_done, illegal, timeout_err, retired
  );

  modport slave (
    output start, halt_req, opcode, mem_ready,
    input  state, ir_we, pc_we, alu_op, alu_src, mem_req, mem_we,
           reg_we, wb_sel, busy, instr_done, illegal, timeout_err, retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// handling the memory ready handshake, memory-wait timeout, illegal opcodes and halt.
module multicycle_control_fsm #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_control_fsm_if.master bus
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    C_R  = 2'd0,
    C_LD = 2'd1,
    C_SD = 2'd2,
    C_BR = 2'd3
  } class_e;

  state_e            state_q, state_d;
  class_e            cls_q, cls_d;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  retired_q;
  logic              illegal_q, timeout_q;

  logic              wait_clr, wait_inc, set_illegal, set_timeout;
  logic              ir_we, pc_we, alu_src, mem_req, mem_we, reg_we, wb_sel, instr_done;
  logic [1:0]        alu_op;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    cls_d       = cls_q;
    wait_clr    = 1'b0;
    wait_inc    = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    alu_op      = ALU_ADD;
    alu_src     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    instr_done  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_FETCH;
          wait_clr = 1'b1;
        end
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = S_HALT;
          set_timeout = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        case (bus.opcode)
          OP_R:    cls_d = C_R;
          OP_LD:   cls_d = C_LD;
          OP_SD:   cls_d = C_SD;
          OP_BR:   cls_d = C_BR;
          OP_SYS:  state_d = S_HALT;
          default: begin
            state_d     = S_HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        unique case (cls_q)
          C_BR: begin
            alu_op     = ALU_SUB;
            instr_done = 1'b1;
          end
          C_R: begin
            alu_op  = ALU_FUNCT;
            state_d = S_WB;
          end
          default: begin
            alu_src  = 1'b1;
            state_d  = S_MEM;
            wait_clr = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        // Only LD/SD reach MEM; keep their address-generation controls steady.
        mem_req = 1'b1;
        mem_we  = (cls_q == C_SD);
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
        if (bus.mem_ready) begin
          if (cls_q == C_LD) state_d = S_WB;
          else               instr_done = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = S_HALT;
          set_timeout = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        wb_sel     = (cls_q == C_LD);
        instr_done = 1'b1;
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase

    // Every retiring cycle commits the PC and decides whether to keep fetching.
    if (instr_done) begin
      pc_we    = 1'b1;
      state_d  = bus.halt_req ? S_IDLE : S_FETCH;
      wait_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cls_q     <= C_R;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cls_q   <= cls_d;
      if (wait_clr)      wait_q <= '0;
      else if (wait_inc) wait_q <= wait_q + WAIT_W'(1);
      if (instr_done)    retired_q <= retired_q + CNT_W'(1);
      if (set_illegal)   illegal_q <= 1'b1;
      if (set_timeout)   timeout_q <= 1'b1;
    end
  end

  assign bus.state       = state_q;
  assign bus.ir_we       = ir_we;
  assign bus.pc_we       = pc_we;
  assign bus.alu_op      = alu_op;
  assign bus.alu_src     = alu_src;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.reg_we      = reg_we;
  assign bus.wb_sel      = wb_sel;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.instr_done  = instr_done;
  assign bus.illegal     = illegal_q;
  assign bus.timeout_err = timeout_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: an instruction-level model expands each instruction into its expected
// per-cycle trace (inputs to drive plus outputs to expect), which is then replayed on the DUT.
module tb_multicycle_control_fsm;

  localparam int MAX   = 15;
  localparam int CNT_W = 4;   // narrow counter so the retire count wraps within the run

  localparam int K_R = 0, K_LD = 1, K_SD = 2, K_BR = 3, K_SYS = 4, K_ILL = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control_fsm #(.MEM_WAIT_MAX(MAX), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        start;
    logic        halt_req;
    logic        mem_ready;
    logic [6:0]  opcode;
    logic [13:0] outs;
    bit          set_ill;
    bit          set_to;
  } cyc_t;

  cyc_t             plan[$];
  int               checks   = 0;
  int               failures = 0;
  int               cyc      = 0;
  logic [CNT_W-1:0] m_retired;
  logic             m_ill, m_to;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [13:0] exp_outs(logic [2:0] st, logic ir, logic pc, logic [1:0] aop,
                                           logic asrc, logic mreq, logic mwe, logic rwe,
                                           logic wsel, logic done);
    logic busy;
    busy = (st != 3'd0) && (st != 3'd6);
    return {st, ir, pc, aop, asrc, mreq, mwe, rwe, wsel, busy, done};
  endfunction

  function automatic logic [13:0] dut_outs();
    return {bus.state, bus.ir_we, bus.pc_we, bus.alu_op, bus.alu_src, bus.mem_req,
            bus.mem_we, bus.reg_we, bus.wb_sel, bus.busy, bus.instr_done};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  function automatic logic [6:0] op_of(int k);
    case (k)
      K_R:     return 7'b0110011;
      K_LD:    return 7'b0000011;
      K_SD:    return 7'b0100011;
      K_BR:    return 7'b1100011;
      K_SYS:   return 7'b1110011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic void push(logic start, logic hreq, logic rdy, logic [6:0] op,
                               logic [13:0] outs, bit si, bit st);
    cyc_t c;
    c.start = start; c.halt_req = hreq; c.mem_ready = rdy; c.opcode = op;
    c.outs = outs; c.set_ill = si; c.set_to = st;
    plan.push_back(c);
  endfunction

  function automatic void idle(logic start);
    push(start, rbit(), rbit(), junk(), exp_outs(3'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0), 0, 0);
  endfunction

  function automatic void halt_cycles(int n);
    for (int i = 0; i < n; i++)
      push(1'b1, rbit(), rbit(), junk(), exp_outs(3'd6, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0), 0, 0);
  endfunction

  // n memory cycles without ready; the MAX-th one times out. Returns 1 on timeout.
  function automatic bit push_waits(logic [2:0] st, int n, logic [1:0] aop, logic asrc, logic mwe);
    for (int i = 0; i < n; i++) begin
      bit last;
      last = (i == MAX - 1);
      push(rbit(), rbit(), 1'b0, junk(), exp_outs(st, 0, 0, aop, asrc, 1, mwe, 0, 0, 0), 0, last);
      if (last) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Expected trace of one instruction starting in FETCH. Returns 1 if it ends in HALT.
  function automatic bit plan_instr(int k, logic [6:0] op, int fw, int mw, logic hreq);
    logic [1:0] aop;
    logic       asrc, is_mem;
    aop    = (k == K_BR) ? 2'b01 : (k == K_R) ? 2'b10 : 2'b00;
    is_mem = (k == K_LD) || (k == K_SD);
    asrc   = is_mem;
    if (push_waits(3'd1, fw, 2'b00, 0, 0)) return 1'b1;
    push(rbit(), rbit(), 1'b1, junk(), exp_outs(3'd1, 1, 0, 2'b00, 0, 1, 0, 0, 0, 0), 0, 0);
    push(rbit(), rbit(), rbit(), op, exp_outs(3'd2, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0), k == K_ILL, 0);
    if (k >= K_SYS) return 1'b1;
    if (k == K_BR) begin
      push(rbit(), hreq, rbit(), junk(), exp_outs(3'd3, 0, 1, aop, asrc, 0, 0, 0, 0, 1), 0, 0);
      return 1'b0;
    end
    push(rbit(), rbit(), rbit(), junk(), exp_outs(3'd3, 0, 0, aop, asrc, 0, 0, 0, 0, 0), 0, 0);
    if (is_mem) begin
      if (push_waits(3'd4, mw, aop, asrc, k == K_SD)) return 1'b1;
      if (k == K_SD) begin
        push(rbit(), hreq, 1'b1, junk(), exp_outs(3'd4, 0, 1, aop, asrc, 1, 1, 0, 0, 1), 0, 0);
        return 1'b0;
      end
      push(rbit(), rbit(), 1'b1, junk(), exp_outs(3'd4, 0, 0, aop, asrc, 1, 0, 0, 0, 0), 0, 0);
    end
    push(rbit(), hreq, rbit(), junk(), exp_outs(3'd5, 0, 1, 2'b00, 0, 0, 0, 1, k == K_LD, 1), 0, 0);
    return 1'b0;
  endfunction

  task automatic check_status(string tag);
    check(tag, {bus.illegal, bus.timeout_err, bus.retired}, {m_ill, m_to, m_retired});
  endtask

  task automatic run();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(negedge clk);
      bus.start = c.start; bus.halt_req = c.halt_req;
      bus.mem_ready = c.mem_ready; bus.opcode = c.opcode;
      #1;
      cyc++;
      check("outs", 64'(dut_outs()), 64'(c.outs));
      check_status("status");
      if (c.outs[0]) m_retired = m_retired + 1'b1;
      if (c.set_ill) m_ill = 1'b1;
      if (c.set_to)  m_to  = 1'b1;
    end
  endtask

  task automatic do_reset(bit now);
    if (!now) @(negedge clk);
    reset = 1'b1;
    #1;
    m_retired = '0; m_ill = 1'b0; m_to = 1'b0;
    check("reset_outs", 64'(dut_outs()), 64'(exp_outs(3'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0)));
    check_status("reset_status");
    bus.start = 1'b0; bus.halt_req = 1'b0; bus.mem_ready = 1'b0; bus.opcode = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0; bus.halt_req = 1'b0; bus.mem_ready = 1'b0; bus.opcode = '0;
    reset = 1'b1;
    m_retired = '0; m_ill = 1'b0; m_to = 1'b0;
    do_reset(1'b1);

    // R, LD with 3 memory stalls, BR, SD with halt at retire, then wait-limit boundary.
    idle(1'b0); idle(1'b1);
    void'(plan_instr(K_R,  op_of(K_R),  0, 0, 1'b0));
    void'(plan_instr(K_LD, op_of(K_LD), 0, 3, 1'b0));
    void'(plan_instr(K_BR, op_of(K_BR), 0, 0, 1'b0));
    void'(plan_instr(K_SD, op_of(K_SD), 0, 0, 1'b1));
    idle(1'b0); idle(1'b1);
    void'(plan_instr(K_LD, op_of(K_LD), MAX - 1, MAX - 1, 1'b0));
    for (int n = 0; n < 40; n++) begin
      int   k, fw, mw;
      logic h;
      k  = $urandom_range(K_R, K_BR);
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      h  = ($urandom_range(0, 7) == 0);
      void'(plan_instr(k, op_of(k), fw, mw, h));
      if (h) begin idle(1'b0); idle(1'b1); end
    end
    run();
    do_reset(1'b0);

    // Illegal opcode: sticky flag, start ignored in HALT.
    idle(1'b1);
    void'(plan_instr(K_ILL, 7'b0000000, 0, 0, 1'b0));
    halt_cycles(3);
    run();
    do_reset(1'b0);

    // Fetch timeout after MAX stalled cycles.
    idle(1'b1);
    void'(plan_instr(K_R, op_of(K_R), MAX, 0, 1'b0));
    halt_cycles(2);
    run();
    do_reset(1'b0);

    // System opcode halts without flagging.
    idle(1'b1);
    void'(plan_instr(K_SYS, op_of(K_SYS), 1, 0, 1'b0));
    halt_cycles(2);
    run();
    do_reset(1'b0);

    // Store timeout in MEM.
    idle(1'b1);
    void'(plan_instr(K_SD, op_of(K_SD), 0, MAX, 1'b0));
    halt_cycles(2);
    run();
    do_reset(1'b0);

    // Reset asserted during a stalled MEM cycle, then restart from IDLE.
    idle(1'b1);
    void'(plan_instr(K_R,  op_of(K_R),  0, 0, 1'b0));
    void'(plan_instr(K_SD, op_of(K_SD), 1, 4, 1'b0));
    for (int i = 0; i < 4; i++) void'(plan.pop_back());
    run();
    do_reset(1'b1);
    idle(1'b1);
    void'(plan_instr(K_BR, op_of(K_BR), 0, 0, 1'b0));
    run();
    @(negedge clk);
    #1;
    check_status("final_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
